fless_checker: RTL and testbench

FLESS_CHECKER -- requirements
Module: fless_checker

---
 rtl/fless_checker.sv | 248 ++++++++++++++++++++++++
 tb/tb_fless_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fless_checker.sv
`default_nettype none
// ============================================================================
// Module   : fless_checker
// Purpose  : Scoreboard for an IEEE-754 single-precision "less than"
//            comparator. It computes a golden op1 < op2 result (denormals
//            flushed to zero, +0 == -0) and compares it with the result
//            reported by the comparator under test. Matches, mismatches and
//            skipped vectors are counted, and the first mismatch is captured.
//            Pipeline: stage 1 holds the operands, the flushed magnitudes and
//            the sign/zero flags. Stage 2 holds the golden result. The
//            counters and capture registers update from stage 2, so a vector
//            accepted at edge N is counted after edge N+2.
// Config   : define FLESS_CHK_NAN_SKIP_EN to exclude NaN operands from
//            checking and count them in skip_count. Otherwise NaN patterns
//            compare as plain magnitudes and skip_count is tied to 0.
// Ports    : clk               - clock, rising edge
//            rstn              - asynchronous active-low reset
//            in_valid/in_ready - vector handshake (in_ready = !clear)
//            op1, op2          - IEEE-754 single operands
//            dut_result        - comparator output under test (1 = op1<op2)
//            clear             - synchronous flush of pipeline/counters/capture
//            pass_count        - saturating count of matching vectors
//            fail_count        - saturating count of mismatching vectors
//            skip_count        - saturating count of excluded vectors
//            first_fail_*      - first mismatching vector and its valid flag
//            busy              - an accepted vector is not yet counted
// Revision : 1.0 - initial release
// ============================================================================
module fless_checker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  input  logic             dut_result,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] skip_count,
  output logic [31:0]      first_fail_op1,
  output logic [31:0]      first_fail_op2,
  output logic             first_fail_result,
  output logic             first_fail_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       C_EXP_MAX = 8'hFF;

  // --------------------------------------------------------------------------
  // Input decode (feeds stage 1)
  // --------------------------------------------------------------------------
  logic        w_accept;
  logic        w_z1;
  logic        w_z2;
  logic [30:0] w_mag1;
  logic [30:0] w_mag2;
  logic        w_nan;

  assign in_ready = !clear;
  assign w_accept = in_valid & in_ready;

  // An exponent of zero means zero or denormal; both are treated as zero.
  assign w_z1   = (op1[30:23] == 8'd0);
  assign w_z2   = (op2[30:23] == 8'd0);
  assign w_mag1 = w_z1 ? 31'd0 : op1[30:0];
  assign w_mag2 = w_z2 ? 31'd0 : op2[30:0];

`ifdef FLESS_CHK_NAN_SKIP_EN
  assign w_nan = ((op1[30:23] == C_EXP_MAX) && (op1[22:0] != 23'd0)) ||
                 ((op2[30:23] == C_EXP_MAX) && (op2[22:0] != 23'd0));
`else
  assign w_nan = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: operands, flushed magnitudes, sign/zero flags
  // --------------------------------------------------------------------------
  logic        r_s1_valid;
  logic [31:0] r_s1_op1;
  logic [31:0] r_s1_op2;
  logic        r_s1_dut;
  logic [30:0] r_s1_mag1;
  logic [30:0] r_s1_mag2;
  logic        r_s1_sgn1;
  logic        r_s1_sgn2;
  logic        r_s1_bothz;
  logic        r_s1_skip;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_op1   <= 32'd0;
      r_s1_op2   <= 32'd0;
      r_s1_dut   <= 1'b0;
      r_s1_mag1  <= 31'd0;
      r_s1_mag2  <= 31'd0;
      r_s1_sgn1  <= 1'b0;
      r_s1_sgn2  <= 1'b0;
      r_s1_bothz <= 1'b0;
      r_s1_skip  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op1   <= op1;
        r_s1_op2   <= op2;
        r_s1_dut   <= dut_result;
        r_s1_mag1  <= w_mag1;
        r_s1_mag2  <= w_mag2;
        r_s1_sgn1  <= op1[31];
        r_s1_sgn2  <= op2[31];
        r_s1_bothz <= w_z1 & w_z2;
        r_s1_skip  <= w_nan;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Golden result from the stage-1 flags and the magnitude compare.
  // Equal patterns fall out as 0 from the strict compares. With both
  // operands zero, the sign bits are ignored so that +0 == -0.
  // --------------------------------------------------------------------------
  logic w_golden;

  always_comb begin
    w_golden = 1'b0;
    if (r_s1_bothz) begin
      w_golden = 1'b0;
    end else if (r_s1_sgn1 != r_s1_sgn2) begin
      w_golden = r_s1_sgn1;
    end else if (!r_s1_sgn1) begin
      w_golden = (r_s1_mag1 < r_s1_mag2);
    end else begin
      w_golden = (r_s1_mag1 > r_s1_mag2);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: golden result plus the data needed for capture
  // --------------------------------------------------------------------------
  logic        r_s2_valid;
  logic        r_s2_golden;
  logic        r_s2_dut;
  logic [31:0] r_s2_op1;
  logic [31:0] r_s2_op2;
  logic        r_s2_skip;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid  <= 1'b0;
      r_s2_golden <= 1'b0;
      r_s2_dut    <= 1'b0;
      r_s2_op1    <= 32'd0;
      r_s2_op2    <= 32'd0;
      r_s2_skip   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid & !clear;
      if (r_s1_valid) begin
        r_s2_golden <= w_golden;
        r_s2_dut    <= r_s1_dut;
        r_s2_op1    <= r_s1_op1;
        r_s2_op2    <= r_s1_op2;
        r_s2_skip   <= r_s1_skip;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters and first-fail capture
  // --------------------------------------------------------------------------
  logic             w_check;
  logic             w_match;
  logic [CNT_W-1:0] r_pass_count;
  logic [CNT_W-1:0] r_fail_count;
  logic [31:0]      r_ff_op1;
  logic [31:0]      r_ff_op2;
  logic             r_ff_result;
  logic             r_ff_valid;

  assign w_check = r_s2_valid & !r_s2_skip;
  assign w_match = (r_s2_golden == r_s2_dut);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pass_count <= '0;
      r_fail_count <= '0;
      r_ff_op1     <= 32'd0;
      r_ff_op2     <= 32'd0;
      r_ff_result  <= 1'b0;
      r_ff_valid   <= 1'b0;
    end else if (clear) begin
      // The vector sitting in stage 2 is discarded along with the others.
      r_pass_count <= '0;
      r_fail_count <= '0;
      r_ff_op1     <= 32'd0;
      r_ff_op2     <= 32'd0;
      r_ff_result  <= 1'b0;
      r_ff_valid   <= 1'b0;
    end else if (w_check) begin
      if (w_match) begin
        if (r_pass_count != C_CNT_MAX) begin
          r_pass_count <= r_pass_count + 1'b1;
        end
      end else begin
        if (r_fail_count != C_CNT_MAX) begin
          r_fail_count <= r_fail_count + 1'b1;
        end
        if (!r_ff_valid) begin
          r_ff_op1    <= r_s2_op1;
          r_ff_op2    <= r_s2_op2;
          r_ff_result <= r_s2_dut;
          r_ff_valid  <= 1'b1;
        end
      end
    end
  end

`ifdef FLESS_CHK_NAN_SKIP_EN
  logic [CNT_W-1:0] r_skip_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_skip_count <= '0;
    end else if (clear) begin
      r_skip_count <= '0;
    end else if (r_s2_valid && r_s2_skip && (r_skip_count != C_CNT_MAX)) begin
      r_skip_count <= r_skip_count + 1'b1;
    end
  end

  assign skip_count = r_skip_count;
`else
  assign skip_count = '0;
`endif

  assign pass_count        = r_pass_count;
  assign fail_count        = r_fail_count;
  assign first_fail_op1    = r_ff_op1;
  assign first_fail_op2    = r_ff_op2;
  assign first_fail_result = r_ff_result;
  assign first_fail_valid  = r_ff_valid;
  assign busy              = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_fless_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fless_checker
// Purpose  : Self-checking bench for fless_checker. It applies a table of
//            directed vectors and then hand-written sequences for capture,
//            back-to-back streaming, clear, NaN handling, saturation and
//            asynchronous reset. Honours FLESS_CHK_NAN_SKIP_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fless_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        dut_result = 1'b0;
  logic        clear = 1'b0;

  logic        in_ready;
  logic [31:0] pass_count, fail_count, skip_count;
  logic [31:0] ff_op1, ff_op2;
  logic        ff_result, ff_valid, busy;

  logic        in_ready2;
  logic [1:0]  pass2, fail2, skip2;
  logic [31:0] ff_op1_2, ff_op2_2;
  logic        ff_result2, ff_valid2, busy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fless_checker #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .dut_result(dut_result), .clear(clear),
    .pass_count(pass_count), .fail_count(fail_count), .skip_count(skip_count),
    .first_fail_op1(ff_op1), .first_fail_op2(ff_op2),
    .first_fail_result(ff_result), .first_fail_valid(ff_valid), .busy(busy)
  );

  fless_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready2),
    .op1(op1), .op2(op2), .dut_result(dut_result), .clear(clear),
    .pass_count(pass2), .fail_count(fail2), .skip_count(skip2),
    .first_fail_op1(ff_op1_2), .first_fail_op2(ff_op2_2),
    .first_fail_result(ff_result2), .first_fail_valid(ff_valid2), .busy(busy2)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        dut;
    logic        gold;   // hand-computed op1 < op2
  } vec_t;

  vec_t tbl [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Accept one vector, then wait until it has been counted.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic d);
    in_valid = 1'b1; op1 = a; op2 = b; dut_result = d;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pass;
    int exp_fail;
    int first_idx;

    //                op1           op2           dut   gold
    tbl[0]  = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0}; // +0 vs -0
    tbl[1]  = '{32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1}; // 1 < 2
    tbl[2]  = '{32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0}; // 2 < 1
    tbl[3]  = '{32'hC000_0000, 32'hBF80_0000, 1'b1, 1'b1}; // -2 < -1
    tbl[4]  = '{32'hBF80_0000, 32'hC000_0000, 1'b0, 1'b0}; // -1 < -2
    tbl[5]  = '{32'h0000_0001, 32'h0040_0000, 1'b0, 1'b0}; // denormals flush equal
    tbl[6]  = '{32'h8000_0001, 32'h3F80_0000, 1'b1, 1'b1}; // -denorm < 1
    tbl[7]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1}; // mismatch (first)
    tbl[8]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0}; // equal
    tbl[9]  = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0}; // mismatch, -0 < +0
    tbl[10] = '{32'h0000_0000, 32'h0080_0000, 1'b1, 1'b1}; // 0 < min normal
    tbl[11] = '{32'h8080_0000, 32'h8000_0001, 1'b1, 1'b1}; // -min normal < -denorm
    tbl[12] = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 1'b1}; // 1 < +inf
    tbl[13] = '{32'hFF80_0000, 32'hFF80_0000, 1'b0, 1'b0}; // -inf vs -inf

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst pass", pass_count, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ffv", {31'd0, ff_valid}, 32'd0);
    #2 rstn = 1'b1;
    #1 chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // ---------------- +0 vs -0, latency ----------------
    in_valid = 1'b1; op1 = 32'h0000_0000; op2 = 32'h8000_0000; dut_result = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("zero busy s1", {31'd0, busy}, 32'd1);
    tick();
    chk("zero pass early", pass_count, 32'd0);
    tick();
    chk("zero pass", pass_count, 32'd1);
    chk("zero fail", fail_count, 32'd0);

    // ---------------- first-fail capture ----------------
    do_clear();
    apply(32'hBF80_0000, 32'h3F80_0000, 1'b0);
    chk("cap fail", fail_count, 32'd1);
    chk("cap op1", ff_op1, 32'hBF80_0000);
    chk("cap op2", ff_op2, 32'h3F80_0000);
    chk("cap res", {31'd0, ff_result}, 32'd0);
    chk("cap valid", {31'd0, ff_valid}, 32'd1);
    apply(32'h4000_0000, 32'h3F80_0000, 1'b1);
    chk("cap2 fail", fail_count, 32'd2);
    chk("cap2 op1", ff_op1, 32'hBF80_0000);
    chk("cap2 res", {31'd0, ff_result}, 32'd0);

    // ---------------- directed table ----------------
    do_clear();
    exp_pass = 0; exp_fail = 0; first_idx = -1;
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].op1, tbl[i].op2, tbl[i].dut);
      if (tbl[i].dut == tbl[i].gold) exp_pass++;
      else begin
        exp_fail++;
        if (first_idx < 0) first_idx = i;
      end
      chk($sformatf("tbl%0d pass", i), pass_count, exp_pass);
      chk($sformatf("tbl%0d fail", i), fail_count, exp_fail);
    end
    chk("tbl ff op1", ff_op1, tbl[first_idx].op1);
    chk("tbl ff op2", ff_op2, tbl[first_idx].op2);
    chk("tbl ff res", {31'd0, ff_result}, {31'd0, tbl[first_idx].dut});
    chk("tbl skip", skip_count, 32'd0);

    // ---------------- back-to-back stream ----------------
    do_clear();
    in_valid = 1'b1;
    op1 = 32'hC000_0000; op2 = 32'hBF80_0000; dut_result = 1'b1; tick();
    op1 = 32'h3F80_0000; op2 = 32'h4000_0000; dut_result = 1'b1; tick();
    op1 = 32'h0000_0001; op2 = 32'h0000_0000; dut_result = 1'b0; tick();
    op1 = 32'h4000_0000; op2 = 32'h3F80_0000; dut_result = 1'b0; tick();
    in_valid = 1'b0;
    tick();
    chk("burst pass L+1", pass_count, 32'd3);
    chk("burst busy L+1", {31'd0, busy}, 32'd1);
    tick();
    chk("burst pass", pass_count, 32'd4);
    chk("burst fail", fail_count, 32'd0);
    chk("burst busy", {31'd0, busy}, 32'd0);

    // ---------------- clear with vectors in flight ----------------
    in_valid = 1'b1; op1 = 32'h3F80_0000; op2 = 32'h4000_0000; dut_result = 1'b1; tick();
    dut_result = 1'b0; tick();
    clear = 1'b1;
    #1 chk("clr in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr pass", pass_count, 32'd0);
    chk("clr fail", fail_count, 32'd0);
    chk("clr busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("clr lost pass", pass_count, 32'd0);
    chk("clr lost fail", fail_count, 32'd0);

    // ---------------- NaN operands ----------------
    apply(32'h7FC0_0000, 32'h3F80_0000, 1'b0);
    apply(32'h3F80_0000, 32'h7F80_0001, 1'b1);
`ifdef FLESS_CHK_NAN_SKIP_EN
    chk("nan skip", skip_count, 32'd2);
    chk("nan pass", pass_count, 32'd0);
`else
    chk("nan skip", skip_count, 32'd0);
    chk("nan pass", pass_count, 32'd2);
`endif
    chk("nan fail", fail_count, 32'd0);

    // ---------------- saturation ----------------
    do_clear();
    in_valid = 1'b1; op1 = 32'h3F80_0000; op2 = 32'h4000_0000; dut_result = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("sat pass2", {30'd0, pass2}, 32'd3);
    chk("sat fail2", {30'd0, fail2}, 32'd0);
    chk("sat pass", pass_count, 32'd5);

    // ---------------- asynchronous reset mid-stream ----------------
    in_valid = 1'b1; op1 = 32'h3F80_0000; op2 = 32'h4000_0000; dut_result = 1'b0; tick();
    dut_result = 1'b1;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst pass", pass_count, 32'd0);
    chk("arst fail", fail_count, 32'd0);
    chk("arst pass2", {30'd0, pass2}, 32'd0);
    chk("arst ffv", {31'd0, ff_valid}, 32'd0);
    chk("arst ffop1", ff_op1, 32'd0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    tick();
    #3 rstn = 1'b1;
    in_valid = 1'b1; op1 = 32'hC000_0000; op2 = 32'hBF80_0000; dut_result = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("post rst pass", pass_count, 32'd1);
    chk("post rst fail", fail_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
